shift_sequencer: RTL and testbench
==================================

Name: shift_sequencer

Overview:
- Multi-cycle controller for the team's single-position shift unit.
- Accepts an operand plus a runtime shift amount, then applies one registered 1-bit shift per clock until the requested amount is reached.
- Reports completion with a one-cycle done pulse and holds the result.
- Sits between the ALU operation decoder and the register-file writeback. It replaces the fixed-amount, fully unrolled shifter with a variable-amount, area-cheap sequential one.

Parameters:
- N, 8, operand/result width in bits (N >= 2).
- SW, $clog2(N)+1, width of the shamt input; must be able to encode the value N.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- A  input  N  operand, captured on the accepted start.
- shamt  input  SW  requested shift amount, captured on the accepted start.
- sel  input  1  fill mode: 0 = logical (zero fill); 1 = arithmetic (right shifts replicate the MSB, left shifts zero-fill).
- dir  input  1  direction: 0 = left, 1 = right.
- result  output  N  shifted operand; valid when done=1 and held until the next accepted start.
- busy  output  1  high from the accept edge until the cycle before done.
- done  output  1  one-cycle completion pulse.
- zero  output  1  result == 0; valid alongside result.

Behaviour:
- One clock domain. Reset is synchronous and active-high: every state change happens on the rising edge of clk, and rst takes priority over everything.
- Reset values:
  - state = IDLE, result = 0, cnt = 0.
  - busy = 0, done = 0, zero = 1.
- FSM states:
  - IDLE: wait for start.
  - SHIFT: perform one step per clock.
  - DONE: assert done for one cycle.
- IDLE transitions (on start = 1):
  - Capture: data_q <= A, sel_q <= sel, dir_q <= dir, cnt <= min(shamt, N).
  - Next state: DONE if the clamped count is 0, otherwise SHIFT.
- SHIFT, each edge:
  - data_q <= step(data_q, sel_q, dir_q) and cnt <= cnt - 1.
  - When cnt == 1, go to DONE.
- DONE: done = 1 for exactly one cycle, then go to IDLE. result keeps data_q.
- Latency: for a start sampled at edge k, done is high during the cycle after edge k + max(shamt, 1) - ... counted as follows:
  - shamt = 0: done high the cycle after the accept.
  - shamt = s > 0: done high after s further edges.
  - Total accept-to-done: s + 1 cycles.
- Clamping: shamt > N is treated as N.
  - Logical shift, either direction: result = 0.
  - Arithmetic right shift: result = all copies of A's MSB.
- start while busy or during DONE is ignored. No queueing.
- A, sel, dir and shamt may change freely after the accept edge; only the captured copies are used.
- Reset asserted mid-operation aborts the operation. On the next edge all outputs return to their reset values and no done pulse is produced.
- busy = (state == SHIFT) or the accept cycle, registered. busy and done are never both high.
- zero is combinational from result.

Optional Feature:
- Macro: SHIFT_SEQ_DOUBLE_STEP_EN.
- With the macro defined: in SHIFT, when cnt >= 2 the block applies two steps in one clock and decrements cnt by 2; otherwise it applies one step and decrements by 1. Accept-to-done latency becomes ceil(s/2) + 1. Results are identical to the single-step build.
- Without the macro: single step only, as specified above.

Decomposition:
- Package shift_seq_pkg holds:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} shift_state_t.
  - Constants SEL_LOGICAL = 0, SEL_ARITH = 1, DIR_LEFT = 0, DIR_RIGHT = 1.
- Sub-module shift_step (combinational, parameter N): a 1-position shift with fill selection.
  - Instantiated once in the default build.
  - Instantiated as a cascade of two under SHIFT_SEQ_DOUBLE_STEP_EN.

Test Plan (N = 8):
- Reset: hold rst 2 cycles mid-idle → result = 0x00, busy = 0, done = 0, zero = 1.
- Logical left: A = 0x81, shamt = 3, sel = 0, dir = 0 → done 4 cycles after the accept, result = 0x08, busy high for 3 cycles.
- Arithmetic right: A = 0x90, shamt = 2, sel = 1, dir = 1 → result = 0xE4. Same case with sel = 0 → 0x24.
- Boundaries:
  - shamt = 0, A = 0x5A → done the next cycle, result = 0x5A.
  - shamt = 12, A = 0xFF, logical right → result = 0x00, zero = 1, latency 9 cycles.
- Ignored start: second start with A = 0x01 issued while busy → first result unaffected, no extra done pulse.
- Mid-op reset: rst pulsed during a shamt = 6 operation → next cycle busy = 0, result = 0, no done pulse. A new start afterwards completes normally.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared types and encodings for the shift sequencer.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shift_state_t;

    localparam logic SEL_LOGICAL = 1'b0;
    localparam logic SEL_ARITH   = 1'b1;
    localparam logic DIR_LEFT    = 1'b0;
    localparam logic DIR_RIGHT   = 1'b1;

endpackage

// File: rtl/shift_step.sv
// One-position shift with fill selection. Arithmetic mode only affects right shifts.
module shift_step
    import shift_seq_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] data_i,
    input  logic         sel_i,
    input  logic         dir_i,
    output logic [N-1:0] data_o
);

    logic fill;

    // Shift by one, filling the vacated bit according to mode and direction
    always_comb begin
        fill   = 1'b0;
        data_o = {data_i[N-2:0], 1'b0};
        if (dir_i == DIR_RIGHT) begin
            fill   = (sel_i == SEL_ARITH) ? data_i[N-1] : 1'b0;
            data_o = {fill, data_i[N-1:1]};
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Sequential variable-amount shifter: one registered shift step per clock.
// Optional build macro SHIFT_SEQ_DOUBLE_STEP_EN applies two steps per clock when possible.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int unsigned N  = 8,
    parameter int unsigned SW = $clog2(N) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  A,
    input  logic [SW-1:0] shamt,
    input  logic          sel,
    input  logic          dir,
    output logic [N-1:0]  result,
    output logic          busy,
    output logic          done,
    output logic          zero
);

    localparam logic [SW-1:0] MaxCnt = SW'(N);

    shift_state_t  state_q, state_d;
    logic [N-1:0]  data_q, data_d;
    logic          sel_q, sel_d;
    logic          dir_q, dir_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;

    logic [SW-1:0] shamt_clamped;
    logic [N-1:0]  step1_data;
    logic [N-1:0]  step_data;
    logic [SW-1:0] step_cnt;

    shift_step #(.N(N)) u_step0 (
        .data_i (data_q),
        .sel_i  (sel_q),
        .dir_i  (dir_q),
        .data_o (step1_data)
    );

`ifdef SHIFT_SEQ_DOUBLE_STEP_EN
    logic [N-1:0] step2_data;

    shift_step #(.N(N)) u_step1 (
        .data_i (step1_data),
        .sel_i  (sel_q),
        .dir_i  (dir_q),
        .data_o (step2_data)
    );

    // Take two steps while at least two remain, otherwise finish with one
    always_comb begin
        step_data = step1_data;
        step_cnt  = SW'(1);
        if (cnt_q >= SW'(2)) begin
            step_data = step2_data;
            step_cnt  = SW'(2);
        end
    end
`else
    // Single-step build: one position per clock
    always_comb begin
        step_data = step1_data;
        step_cnt  = SW'(1);
    end
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            sel_q   <= SEL_LOGICAL;
            dir_q   <= DIR_LEFT;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d       = state_q;
        data_d        = data_q;
        sel_d         = sel_q;
        dir_d         = dir_q;
        cnt_d         = cnt_q;
        shamt_clamped = (shamt > MaxCnt) ? MaxCnt : shamt;
        case (state_q)
            IDLE: begin
                if (start) begin
                    data_d  = A;
                    sel_d   = sel;
                    dir_d   = dir;
                    cnt_d   = shamt_clamped;
                    state_d = (shamt_clamped == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                data_d = step_data;
                cnt_d  = cnt_q - step_cnt;
                if (cnt_q <= step_cnt) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // busy is registered so it tracks the state we are about to enter
        busy_d = (state_d == SHIFT);
    end

    // Outputs
    always_comb begin
        result = data_q;
        zero   = (data_q == '0);
        done   = (state_q == DONE);
        busy   = busy_q;
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer (N = 8) with a result scoreboard.
module tb_shift_sequencer;

    typedef struct {
        logic [7:0] res;
        int         lat;
        int         busy_cycles;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] A;
    logic [3:0] shamt;
    logic       sel;
    logic       dir;
    logic [7:0] result;
    logic       busy;
    logic       done;
    logic       zero;

    int   n_cmp;
    int   n_fail;
    exp_t sb[$];

    shift_sequencer #(.N(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .A      (A),
        .shamt  (shamt),
        .sel    (sel),
        .dir    (dir),
        .result (result),
        .busy   (busy),
        .done   (done),
        .zero   (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [3:0] s,
                                   input logic sl, input logic dr);
        exp_t e;
        int   c;
        c = (int'(s) > 8) ? 8 : int'(s);
        if (!dr) e.res = (c >= 8) ? 8'h00 : 8'(a << c);
        else if (sl) e.res = 8'($signed(a) >>> c);
        else e.res = (c >= 8) ? 8'h00 : 8'(a >> c);
`ifdef SHIFT_SEQ_DOUBLE_STEP_EN
        e.lat = (c + 1) / 2 + 1;
`else
        e.lat = c + 1;
`endif
        e.busy_cycles = e.lat - 1;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, optionally retrigger start at busy cycle 'disturb', then check it
    task automatic run_op(input string tag, input logic [7:0] a, input logic [3:0] s,
                          input logic sl, input logic dr, input int disturb);
        exp_t e;
        int   lat;
        int   bcnt;
        int   npulse;
        bit   seen;
        A     = a;
        shamt = s;
        sel   = sl;
        dir   = dr;
        start = 1'b1;
        sb.push_back(model(a, s, sl, dr));
        tick();
        // Scramble inputs after the accept; only captured copies may matter
        start = 1'b0;
        A     = ~a;
        shamt = s + 4'd1;
        sel   = ~sl;
        dir   = ~dr;
        lat   = 1;
        bcnt  = 0;
        seen  = 1'b0;
        while (lat <= 40) begin
            check({tag, "_busy_done_overlap"}, 32'(busy & done), 0);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) bcnt++;
            if (lat == disturb) begin
                A     = 8'h01;
                shamt = 4'd1;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            lat++;
        end
        start = 1'b0;
        check({tag, "_done_seen"}, 32'(seen), 1);
        e = sb.pop_front();
        check({tag, "_result"}, 32'(result), 32'(e.res));
        check({tag, "_zero"}, 32'(zero), 32'(e.res == 8'h00));
        check({tag, "_latency"}, lat, e.lat);
        check({tag, "_busy_cycles"}, bcnt, e.busy_cycles);
        npulse = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done) npulse++;
            check({tag, "_result_held"}, 32'(result), 32'(e.res));
            check({tag, "_busy_after"}, 32'(busy), 0);
        end
        check({tag, "_extra_done"}, npulse, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_result"}, 32'(result), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_zero"}, 32'(zero), 1);
    endtask

    initial begin
        int npulse;
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        start  = 1'b0;
        A      = 8'h00;
        shamt  = 4'd0;
        sel    = 1'b0;
        dir    = 1'b0;
        tick();
        tick();
        check_reset_outputs("por");
        rst = 1'b0;
        tick();

        run_op("lsl3", 8'h81, 4'd3, 1'b0, 1'b0, 0);
        // Reset held two cycles while idle with a non-zero result
        rst = 1'b1;
        tick();
        tick();
        check_reset_outputs("idle_rst");
        rst = 1'b0;
        tick();

        run_op("asr2", 8'h90, 4'd2, 1'b1, 1'b1, 0);
        run_op("lsr2", 8'h90, 4'd2, 1'b0, 1'b1, 0);
        run_op("sh0", 8'h5A, 4'd0, 1'b0, 1'b0, 0);
        run_op("lsr12", 8'hFF, 4'd12, 1'b0, 1'b1, 0);
        run_op("asr12", 8'hA5, 4'd12, 1'b1, 1'b1, 0);
        run_op("asl8", 8'hFF, 4'd8, 1'b1, 1'b0, 0);
        run_op("ignored", 8'h3C, 4'd4, 1'b0, 1'b0, 2);
        run_op("ign_last", 8'hC3, 4'd3, 1'b1, 1'b1, 3);

        // Reset in the middle of a 6-step operation
        A     = 8'h7E;
        shamt = 4'd6;
        sel   = 1'b0;
        dir   = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_reset_outputs("mid_rst");
        rst    = 1'b0;
        npulse = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) npulse++;
        end
        check("mid_rst_no_done", npulse, 0);
        check("mid_rst_busy", 32'(busy), 0);
        run_op("post_rst", 8'h7E, 4'd6, 1'b0, 1'b1, 0);

        for (int k = 0; k < 10; k++) begin
            run_op("rand", 8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom),
                   1'($urandom), 0);
        end

        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
